// File: rtl/cpu_pipe_ctrl.sv
// Pipeline control for the staged MIPS core: per-stage valid tracking, load-use
// stall/bubble, branch flush, RUN/DRAIN/HALTED halt sequencing and debug counters.
module cpu_pipe_ctrl #(
    parameter int STAGES = 5,
    parameter int CNT_W  = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [REG_W-1:0]  id_rs_num,
    input  logic [REG_W-1:0]  id_rt_num,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              ex_mem_read,
    input  logic [REG_W-1:0]  ex_rd_num,
    input  logic              branch_taken,
    input  logic              halt_req,
    output logic [STAGES-1:0] stage_valid,
    output logic              stall,
    output logic              bubble,
    output logic              flush,
    output logic              halt,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  retired_count,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

    state_t            state_q, state_d;
    logic [STAGES-1:0] valid_q, valid_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d, ret_q, ret_d, stl_q, stl_d, fls_q, fls_d;

    logic run, drain, active, ex_act, hz, h, flush_c, stall_c;

    always_comb begin
        run     = (state_q == ST_RUN);
        drain   = (state_q == ST_DRAIN);
        active  = run | drain;
        ex_act  = valid_q[2];
        hz      = ex_act & ex_mem_read & (ex_rd_num != '0) & valid_q[1] &
                  ((id_uses_rs & (id_rs_num == ex_rd_num)) |
                   (id_uses_rt & (id_rt_num == ex_rd_num)));
        // Halt outranks flush, which outranks the load-use stall.
        h       = ex_act & halt_req & run;
        flush_c = ex_act & branch_taken & ~h & run;
        stall_c = hz & ~flush_c & ~h & run;
    end

    always_comb begin
        valid_d = '0;
        for (int i = 3; i < STAGES; i++) begin
            valid_d[i] = active & valid_q[i-1];
        end
        // The halting instruction itself still advances into stage 3 above.
        valid_d[2] = active & ~(stall_c | flush_c | h | drain) & valid_q[1];
        valid_d[1] = stall_c ? valid_q[1] : (active & ~(flush_c | h | drain) & valid_q[0]);
        valid_d[0] = stall_c ? valid_q[0] : (active & ~(h | drain));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (h) state_d = ST_DRAIN;
            ST_DRAIN:  if (valid_d[STAGES-1:3] == '0) state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    always_comb begin
        cyc_d = cyc_q + CNT_W'(active);
        ret_d = ret_q + CNT_W'(valid_q[STAGES-1] & active);
        stl_d = stl_q + CNT_W'(stall_c);
        fls_d = fls_q + CNT_W'(flush_c);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_RUN;
            valid_q <= '0;
            cyc_q   <= '0;
            ret_q   <= '0;
            stl_q   <= '0;
            fls_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            cyc_q   <= cyc_d;
            ret_q   <= ret_d;
            stl_q   <= stl_d;
            fls_q   <= fls_d;
        end
    end

    assign stage_valid   = valid_q;
    assign stall         = stall_c;
    assign bubble        = stall_c;
    assign flush         = flush_c;
    assign halt          = (state_q == ST_HALTED);
    assign cycle_count   = cyc_q;
    assign retired_count = ret_q;
    assign stall_count   = stl_q;
    assign flush_count   = fls_q;

endmodule
